// File: rtl/seq_match_pkg.sv
// Shared types and helpers for the programmable serial pattern-match engine.
package seq_match_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Length 0 behaves as 1; anything beyond the history depth is clamped.
    function automatic int unsigned plen_clamp(input int unsigned plen, input int unsigned max_len);
        if (plen == 0)
            return 1;
        else if (plen > max_len)
            return max_len;
        else
            return plen;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill tracking and masked compare; flags a hit on the accepting bit.
module seq_match_core #(
    parameter int PAT_W  = 8,
    parameter int PLEN_W = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              accept,
    input  logic              din,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [PLEN_W-1:0] plen,
    input  logic              overlap,
    output logic              hit
);

    logic [PAT_W-1:0]  hist, hist_nxt, mask;
    logic [PLEN_W-1:0] fill, fill_nxt;

    for (genvar g = 0; g < PAT_W; g++) begin : g_mask
        assign mask[g] = (plen > PLEN_W'(g));
    end

    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], din};
        fill_nxt = (fill >= plen) ? plen : fill + PLEN_W'(1);
        hit      = accept && (fill_nxt == plen) && (((hist_nxt ^ pattern) & mask) == '0);
    end

    // Non-overlap mode restarts from empty history so the next match needs plen fresh bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (clr || (hit && !overlap)) begin
            hist <= '0;
            fill <= '0;
        end else if (accept) begin
            hist <= hist_nxt;
            fill <= fill_nxt;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Run controller: config latch, window counting, Mealy/Moore match timing and match counting.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_plen,
    input  logic                       cfg_overlap,
    input  logic                       cfg_moore,
    input  logic [WIN_W-1:0]           cfg_window,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       din_valid,
    input  logic                       din,
    output logic                       din_ready,
    output logic                       busy,
    output logic                       match,
    output logic                       done,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_ovf
);

    localparam int PLEN_W = $clog2(PAT_W + 1);

    state_t            state, state_nxt;
    logic [PAT_W-1:0]  pat_q;
    logic [PLEN_W-1:0] plen_q;
    logic              overlap_q, moore_q;
    logic [WIN_W-1:0]  win_q, bit_cnt;
    logic              moore_hit_q;
    logic              go, accept, last, hit;

    assign go = (state == S_IDLE) && start;
    // An aborting cycle consumes nothing, so abort always beats a final accept.
    assign din_ready = (state == S_RUN) && !abort;
    assign accept    = din_valid && din_ready;
    assign last      = accept && ((bit_cnt + WIN_W'(1)) == win_q);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign match     = moore_q ? moore_hit_q : hit;

    seq_match_core #(.PAT_W(PAT_W), .PLEN_W(PLEN_W)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (go),
        .accept  (accept),
        .din     (din),
        .pattern (pat_q),
        .plen    (plen_q),
        .overlap (overlap_q),
        .hit     (hit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (cfg_window == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (abort)     state_nxt = S_IDLE;
                else if (last) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q     <= '0;
            plen_q    <= PLEN_W'(1);
            overlap_q <= 1'b0;
            moore_q   <= 1'b0;
            win_q     <= '0;
        end else if (go) begin
            pat_q     <= cfg_pattern;
            plen_q    <= PLEN_W'(plen_clamp(32'(cfg_plen), PAT_W));
            overlap_q <= cfg_overlap;
            moore_q   <= cfg_moore;
            win_q     <= cfg_window;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            moore_hit_q <= 1'b0;
            match_cnt   <= '0;
            cnt_ovf     <= 1'b0;
        end else if (go) begin
            bit_cnt     <= '0;
            moore_hit_q <= 1'b0;
            match_cnt   <= '0;
            cnt_ovf     <= 1'b0;
        end else begin
            moore_hit_q <= hit && moore_q;
            if (accept) bit_cnt <= bit_cnt + WIN_W'(1);
            if (hit) begin
                if (&match_cnt) cnt_ovf   <= 1'b1;
                else            match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl: one task per scenario with inline expected values.
module tb_seq_match_ctrl;

    localparam int PAT_W  = 8;
    localparam int CNT_W  = 2;
    localparam int WIN_W  = 16;
    localparam int PLEN_W = $clog2(PAT_W + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [PAT_W-1:0]  cfg_pattern = '0;
    logic [PLEN_W-1:0] cfg_plen = '0;
    logic              cfg_overlap = 1'b0;
    logic              cfg_moore = 1'b0;
    logic [WIN_W-1:0]  cfg_window = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              din_valid = 1'b0;
    logic              din = 1'b0;
    logic              din_ready, busy, match, done, cnt_ovf;
    logic [CNT_W-1:0]  match_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_pattern (cfg_pattern),
        .cfg_plen    (cfg_plen),
        .cfg_overlap (cfg_overlap),
        .cfg_moore   (cfg_moore),
        .cfg_window  (cfg_window),
        .start       (start),
        .abort       (abort),
        .din_valid   (din_valid),
        .din         (din),
        .din_ready   (din_ready),
        .busy        (busy),
        .match       (match),
        .done        (done),
        .match_cnt   (match_cnt),
        .cnt_ovf     (cnt_ovf)
    );

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic v, input logic d, input logic s, input logic a);
        @(negedge clk);
        din_valid = v; din = d; start = s; abort = a;
        #1;
    endtask

    task automatic set_cfg(input logic [PAT_W-1:0] p, input logic [PLEN_W-1:0] l,
                           input logic ov, input logic mo, input logic [WIN_W-1:0] w);
        cfg_pattern = p; cfg_plen = l; cfg_overlap = ov; cfg_moore = mo; cfg_window = w;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({din_ready, busy, match, done, cnt_ovf} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {din_ready, busy, match, done, cnt_ovf}); end
        checks++; if (match_cnt !== '0) begin
            failures++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    // Stream 1,0,1,0,1 against pattern 101/plen 3, window 5.
    task automatic run_10101(input string name, input logic ov, input logic mo,
                             input logic [4:0] exp_m, input logic exp_done_m, input int exp_cnt);
        logic [4:0] bits;
        bits = 5'b10101;
        set_cfg(8'b101, 4'd3, ov, mo, 16'd5);
        drive(0, 0, 1, 0);
        checks++; if (din_ready !== 1'b0) begin
            failures++; $display("FAIL %s idle_ready got=%b exp=0", name, din_ready); end
        for (int i = 0; i < 5; i++) begin
            drive(1, bits[4-i], 0, 0);
            checks++; if (match !== exp_m[4-i]) begin
                failures++; $display("FAIL %s match_bit%0d got=%b exp=%b", name, i + 1, match, exp_m[4-i]); end
            checks++; if ({din_ready, done} !== 2'b10) begin
                failures++; $display("FAIL %s run_flags_bit%0d got=%b exp=10", name, i + 1, {din_ready, done}); end
        end
        drive(0, 0, 0, 0);
        checks++; if ({done, busy, din_ready, match} !== {3'b110, exp_done_m}) begin
            failures++; $display("FAIL %s done_flags got=%b exp=%b", name, {done, busy, din_ready, match}, {3'b110, exp_done_m}); end
        checks++; if (match_cnt !== CNT_W'(exp_cnt) || cnt_ovf !== 1'b0) begin
            failures++; $display("FAIL %s done_cnt got=%0d/%b exp=%0d/0", name, match_cnt, cnt_ovf, exp_cnt); end
        drive(0, 0, 0, 0);
        checks++; if ({done, busy, match} !== 3'b000) begin
            failures++; $display("FAIL %s back_idle got=%b exp=000", name, {done, busy, match}); end
    endtask

    task automatic test_mealy_overlap;    run_10101("mealy_ovl",   1, 0, 5'b00101, 1'b0, 2); endtask
    task automatic test_mealy_nonoverlap; run_10101("mealy_noovl", 0, 0, 5'b00100, 1'b0, 1); endtask
    task automatic test_moore_overlap;    run_10101("moore_ovl",   1, 1, 5'b00010, 1'b1, 2); endtask

    task automatic test_saturate;
        set_cfg(8'b1, 4'd1, 1, 0, 16'd5);
        drive(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0);
            checks++; if (match !== 1'b1 || match_cnt !== CNT_W'(i > 3 ? 3 : i) || cnt_ovf !== (i >= 4)) begin
                failures++; $display("FAIL sat_bit%0d got=%b/%0d/%b exp=1/%0d/%b",
                                     i + 1, match, match_cnt, cnt_ovf, (i > 3 ? 3 : i), (i >= 4)); end
        end
        drive(0, 0, 0, 0);
        checks++; if (done !== 1'b1 || match_cnt !== 2'd3 || cnt_ovf !== 1'b1) begin
            failures++; $display("FAIL sat_done got=%b/%0d/%b exp=1/3/1", done, match_cnt, cnt_ovf); end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_abort_gaps;
        logic [4:0] v, d, m;
        v = 5'b10101; d = 5'b10001; m = 5'b00001;
        set_cfg(8'b101, 4'd3, 1, 0, 16'd6);
        drive(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(v[4-i], d[4-i], 0, 0);
            checks++; if (match !== m[4-i]) begin
                failures++; $display("FAIL abort_match_step%0d got=%b exp=%b", i, match, m[4-i]); end
        end
        drive(0, 0, 1, 0);
        checks++; if (busy !== 1'b1 || match_cnt !== 2'd1) begin
            failures++; $display("FAIL abort_start_ignored got=%b/%0d exp=1/1", busy, match_cnt); end
        drive(0, 0, 0, 1);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL abort_cycle got=%b/%b exp=0/1", done, busy); end
        drive(0, 0, 0, 0);
        checks++; if ({busy, done, din_ready} !== 3'b000 || match_cnt !== 2'd1) begin
            failures++; $display("FAIL abort_idle got=%b/%0d exp=000/1", {busy, done, din_ready}, match_cnt); end
        drive(0, 0, 0, 0);
        checks++; if (done !== 1'b0) begin
            failures++; $display("FAIL abort_no_done got=%b exp=0", done); end
    endtask

    task automatic test_abort_final;
        set_cfg(8'b1, 4'd1, 1, 0, 16'd2);
        drive(0, 0, 1, 0);
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 1);
        checks++; if (match !== 1'b0) begin
            failures++; $display("FAIL abort_final_match got=%b exp=0", match); end
        drive(0, 0, 0, 0);
        checks++; if ({busy, done} !== 2'b00 || match_cnt !== 2'd1) begin
            failures++; $display("FAIL abort_final_state got=%b/%0d exp=00/1", {busy, done}, match_cnt); end
    endtask

    task automatic test_window_zero;
        set_cfg(8'b1, 4'd0, 1, 0, 16'd0);
        drive(0, 0, 1, 0);
        checks++; if (din_ready !== 1'b0) begin
            failures++; $display("FAIL win0_ready_start got=%b exp=0", din_ready); end
        drive(1, 1, 0, 0);
        checks++; if ({done, busy, din_ready, match} !== 4'b1100 || match_cnt !== 2'd0) begin
            failures++; $display("FAIL win0_done got=%b/%0d exp=1100/0", {done, busy, din_ready, match}, match_cnt); end
        drive(0, 0, 0, 0);
        checks++; if ({done, busy, din_ready} !== 3'b000) begin
            failures++; $display("FAIL win0_idle got=%b exp=000", {done, busy, din_ready}); end
    endtask

    task automatic test_async_reset;
        set_cfg(8'b101, 4'd3, 1, 1, 16'd5);
        drive(0, 0, 1, 0);
        drive(1, 1, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        @(posedge clk); #2;
        checks++; if (match !== 1'b1) begin
            failures++; $display("FAIL arst_pending got=%b exp=1", match); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, match, done, din_ready} !== 4'b0 || match_cnt !== '0) begin
            failures++; $display("FAIL arst_clear got=%b/%0d exp=0000/0", {busy, match, done, din_ready}, match_cnt); end
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        checks++; if ({busy, done, match} !== 3'b000) begin
            failures++; $display("FAIL arst_after got=%b exp=000", {busy, done, match}); end
    endtask

    initial begin
        test_reset();
        test_mealy_overlap();
        test_mealy_nonoverlap();
        test_moore_overlap();
        test_saturate();
        test_abort_gaps();
        test_abort_final();
        test_window_zero();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
Run-time-configurable serial pattern-match controller for the sequence-detection datapath. It replaces fixed-pattern detector FSMs with a single programmable engine. Software/testbench configures pattern, pattern length, overlap mode and Mealy/Moore output timing, then starts a detection window over a valid/ready bit stream. The block sequences the run, counts matches and reports completion.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter
WIN_W, 16, width of window (bit-count) register

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_pattern  in  PAT_W  pattern; bit [plen-1] is first bit received, bit [0] last
cfg_plen  in  $clog2(PAT_W+1)  pattern length; 0 treated as 1, >PAT_W clamped to PAT_W
cfg_overlap  in  1  1=overlapping matches allowed, 0=history cleared after each match
cfg_moore  in  1  0=Mealy timing, 1=Moore timing for match
cfg_window  in  WIN_W  number of bits to accept per run
start  in  1  one-cycle run request, honoured only in IDLE
abort  in  1  terminate run, honoured only in RUN
din_valid  in  1  serial bit valid
din  in  1  serial bit
din_ready  out  1  high in RUN only
busy  out  1  high in RUN and DONE
match  out  1  one-cycle match pulse
done  out  1  one-cycle completion pulse
match_cnt  out  CNT_W  matches in current/last run, saturating
cnt_ovf  out  1  sticky: a match occurred while match_cnt was all-ones

Behaviour:
- Reset: state IDLE; din_ready, busy, match, done, match_cnt, cnt_ovf all 0; history and fill cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch all cfg_* (config ignored thereafter until next start), clear match_cnt, cnt_ovf, history, fill and bit counter; next state RUN. If latched window=0 -> next state DONE directly.
- RUN: din_ready=1. Accept = din_valid & din_ready. Each accept: history <= {history, din}; bit counter +1; fill = min(fill+1, plen).
- Match condition (on accept): fill_after>=plen and low plen bits of {history,din} == low plen bits of pattern.
- Mealy: match asserted combinationally in the accepting cycle. Moore: match registered, asserted the cycle after acceptance.
- On match: match_cnt +1 unless all-ones, in which case hold and set cnt_ovf. Non-overlap mode: history and fill cleared to 0 at the match, so the next match needs plen fresh bits.
- Accept bringing bit counter to window -> next state DONE. Accepts without din_valid gaps are allowed every cycle; gaps simply stall.
- abort in RUN -> IDLE next cycle, no done; match_cnt holds partial count. No Moore match is emitted after abort (pending pulse dropped). abort wins over a simultaneous final accept.
- DONE: done=1 for exactly one cycle, din_ready=0; next state IDLE. A Moore match for the final bit coincides with done. match_cnt stable from done until next start.
- start in RUN/DONE ignored; abort in IDLE/DONE ignored.
- Asynchronous reset mid-run: immediate return to reset values; no done.

Decomposition:
- Package seq_match_pkg: state encoding constants (IDLE, RUN, DONE) and plen clamp function.
- Sub-module seq_match_core: history shift register, fill counter, masked comparator, overlap clear; outputs raw hit per accept. Controller (FSM, window counter, match timing, match_cnt) in seq_match_ctrl.

Test Plan:
- pattern=3'b101, plen=3, overlap=1, Mealy, window=5, stream 1,0,1,0,1 back-to-back -> match in cycles accepting bits 3 and 5; done the cycle after bit 5; match_cnt=2.
- Same stream, overlap=0 -> single match on bit 3; match_cnt=1, cnt_ovf=0.
- Same as first, cfg_moore=1 -> match pulses one cycle after bits 3 and 5; second pulse coincident with done; match_cnt=2.
- CNT_W=2, pattern=1'b1, plen=1, window=5, stream all ones -> match_cnt saturates at 3, cnt_ovf=1 after 4th match; done after bit 5.
- window=6, din_valid toggled 1,0,1,0..., abort asserted after 3rd accept -> IDLE next cycle, no done, busy=0, match_cnt equals partial count; start during run ignored.
- plen=0 with pattern=1, window=0 -> done 1 cycle after start, match_cnt=0, din_ready never high.
